// File: rtl/morse_code_transmitter.sv
// Morse keyer: sends up to MAX_SYMS dot/dash symbols per letter on led with unit timing from CLOCK_50.
// Optional inter-letter spacing state is enabled by defining MORSE_LETTER_GAP_EN.
module morse_code_transmitter #(
   parameter int unsigned MAX_SYMS         = 4,
   parameter int unsigned LEN_W            = 3,
   parameter int unsigned CLK_DIV          = 25000000,
   parameter int unsigned DASH_UNITS       = 3,
   parameter int unsigned GAP_UNITS        = 1,
   parameter int unsigned LETTER_GAP_UNITS = 3
) (
   input  logic                CLOCK_50,
   input  logic                resetn,
   input  logic                start,
   input  logic [MAX_SYMS-1:0] pattern_in,
   input  logic [LEN_W-1:0]    length_in,
   output logic                ready,
   output logic                busy,
   output logic                led,
   output logic                done
);

   localparam int unsigned CNT_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned MAX_UNITS =
      (DASH_UNITS > GAP_UNITS) ?
         ((DASH_UNITS > LETTER_GAP_UNITS) ? DASH_UNITS : LETTER_GAP_UNITS) :
         ((GAP_UNITS > LETTER_GAP_UNITS) ? GAP_UNITS : LETTER_GAP_UNITS);
   localparam int unsigned UNIT_W    = $clog2(MAX_UNITS + 1);

   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV - 1);
   localparam logic [UNIT_W-1:0] DOT_LAST  = '0;
   localparam logic [UNIT_W-1:0] DASH_LAST = UNIT_W'(DASH_UNITS - 1);
   localparam logic [UNIT_W-1:0] GAP_LAST  = UNIT_W'(GAP_UNITS - 1);
   localparam logic [LEN_W-1:0]  MAX_LEN   = LEN_W'(MAX_SYMS);

`ifdef MORSE_LETTER_GAP_EN
   localparam logic [UNIT_W-1:0] LGAP_LAST = UNIT_W'(LETTER_GAP_UNITS - 1);
   typedef enum logic [1:0] {StIdle, StMark, StGap, StLgap} state_e;
`else
   typedef enum logic [1:0] {StIdle, StMark, StGap} state_e;
`endif

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [UNIT_W-1:0]   ucnt_q, ucnt_d;
   logic [MAX_SYMS-1:0] shreg_q, shreg_d;
   logic [LEN_W-1:0]    idx_q, idx_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic                led_q, led_d;
   logic                ready_q, ready_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic                tick;
   logic                unit_done;
   logic                more_syms;
   logic [UNIT_W-1:0]   unit_last;
   logic [LEN_W-1:0]    eff_len;

   always_comb begin
      eff_len   = (length_in > MAX_LEN) ? MAX_LEN : length_in;
      tick      = (cnt_q == CNT_LAST);
      more_syms = ({1'b0, idx_q} + {{LEN_W{1'b0}}, 1'b1}) < {1'b0, len_q};

      unit_last = '0;
      unique case (state_q)
         StMark:  unit_last = shreg_q[0] ? DASH_LAST : DOT_LAST;
         StGap:   unit_last = GAP_LAST;
`ifdef MORSE_LETTER_GAP_EN
         StLgap:  unit_last = LGAP_LAST;
`endif
         default: unit_last = '0;
      endcase
      unit_done = tick && (ucnt_q == unit_last);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ucnt_d  = ucnt_q;
      shreg_d = shreg_q;
      idx_d   = idx_q;
      len_d   = len_q;
      led_d   = led_q;
      ready_d = ready_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      // Unit timer free-runs in every non-idle state; each state entry below restarts it.
      if (state_q != StIdle) begin
         if (tick) begin
            cnt_d  = '0;
            ucnt_d = ucnt_q + UNIT_W'(1);
         end else begin
            cnt_d  = cnt_q + CNT_W'(1);
         end
      end

      unique case (state_q)
         StIdle: begin
            if (start && ready_q) begin
               shreg_d = pattern_in;
               len_d   = eff_len;
               idx_d   = '0;
               cnt_d   = '0;
               ucnt_d  = '0;
               if (eff_len == '0) begin
`ifdef MORSE_LETTER_GAP_EN
                  state_d = StLgap;
                  ready_d = 1'b0;
                  busy_d  = 1'b1;
`else
                  done_d  = 1'b1;
`endif
               end else begin
                  state_d = StMark;
                  led_d   = 1'b1;
                  ready_d = 1'b0;
                  busy_d  = 1'b1;
               end
            end
         end

         StMark: begin
            if (unit_done) begin
               cnt_d  = '0;
               ucnt_d = '0;
               led_d  = 1'b0;
               if (more_syms) begin
                  shreg_d = shreg_q >> 1;
                  idx_d   = idx_q + LEN_W'(1);
                  state_d = StGap;
               end else begin
`ifdef MORSE_LETTER_GAP_EN
                  state_d = StLgap;
`else
                  state_d = StIdle;
                  ready_d = 1'b1;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
`endif
               end
            end
         end

         StGap: begin
            if (unit_done) begin
               cnt_d   = '0;
               ucnt_d  = '0;
               led_d   = 1'b1;
               state_d = StMark;
            end
         end

`ifdef MORSE_LETTER_GAP_EN
         StLgap: begin
            if (unit_done) begin
               cnt_d   = '0;
               ucnt_d  = '0;
               state_d = StIdle;
               ready_d = 1'b1;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
`endif

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         ucnt_q  <= '0;
         shreg_q <= '0;
         idx_q   <= '0;
         len_q   <= '0;
         led_q   <= 1'b0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ucnt_q  <= ucnt_d;
         shreg_q <= shreg_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         led_q   <= led_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign ready = ready_q;
   assign busy  = busy_q;
   assign led   = led_q;
   assign done  = done_q;

endmodule
